tlb_inv_engine: RTL and testbench

Multi-cycle sequencer that executes committed INVTLB operations against the TLB entry array. It sits directly downstream of the commit controller, consuming its `inv_o` request and returning `inv_stallreq`, which holds the backend until the walk completes. The engine scans TLB entries one per cycle through a registered read port, matches each entry against the latched op/ASID/VPPN, and clears the E bit of every matching entry.

---
 rtl/tlb_inv_engine_pkg.sv | 30 +++
 rtl/tlb_inv_match.sv | 40 ++++
 rtl/tlb_inv_engine.sv | 154 +++++++++++++++
 tb/tb_tlb_inv_engine.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_inv_engine_pkg.sv
// Shared TLB types for the INVTLB engine: request struct, FSM state
// encoding, INVTLB op codes and the 4MB page-size code.
package tlb_types;

    typedef struct packed {
        logic        en;
        logic [4:0]  op;
        logic [9:0]  asid;
        logic [18:0] vpn;
    } tlb_inv_t;

    typedef enum logic [2:0] {
        IDLE,
        WALK,
        DRAIN,
        DONE,
        FLASH
    } inv_state_t;

    localparam logic [4:0] INV_OP_ALL0         = 5'd0;
    localparam logic [4:0] INV_OP_ALL1         = 5'd1;
    localparam logic [4:0] INV_OP_G1           = 5'd2;
    localparam logic [4:0] INV_OP_G0           = 5'd3;
    localparam logic [4:0] INV_OP_ASID         = 5'd4;
    localparam logic [4:0] INV_OP_ASID_VA      = 5'd5;
    localparam logic [4:0] INV_OP_G_OR_ASID_VA = 5'd6;

    localparam logic [5:0] PS_4M = 6'd21;

endpackage

// File: rtl/tlb_inv_match.sv
// Combinational INVTLB entry comparator: decides whether one TLB entry is
// selected by the latched op/ASID/VPN. The E bit is qualified by the caller.
module tlb_inv_match
    import tlb_types::*;
(
    input  logic [4:0]  op,
    input  logic [9:0]  asid,
    input  logic [18:0] vpn,
    input  logic        ent_g,
    input  logic [9:0]  ent_asid,
    input  logic [18:0] ent_vppn,
    input  logic [5:0]  ent_ps,
    output logic        match
);

    logic asid_eq;
    logic vppn_eq;

    // Field compares and per-op selection; a 4MB page ignores VPPN bits below 9
    always_comb begin
        asid_eq = (ent_asid == asid);
        if (ent_ps == PS_4M) begin
            vppn_eq = (ent_vppn[18:9] == vpn[18:9]);
        end else begin
            vppn_eq = (ent_vppn == vpn);
        end
        match = 1'b0;
        case (op)
            INV_OP_ALL0,
            INV_OP_ALL1:         match = 1'b1;
            INV_OP_G1:           match = ent_g;
            INV_OP_G0:           match = !ent_g;
            INV_OP_ASID:         match = !ent_g && asid_eq;
            INV_OP_ASID_VA:      match = !ent_g && asid_eq && vppn_eq;
            INV_OP_G_OR_ASID_VA: match = (ent_g || asid_eq) && vppn_eq;
            default:             match = 1'b0;
        endcase
    end

endmodule

// File: rtl/tlb_inv_engine.sv
// INVTLB sequencer: accepts a committed INVTLB, walks every TLB entry through
// the registered read port, and clears E on each matching entry one cycle
// after its read. Holds the backend stalled until the walk completes.
// Optional feature macro: INVTLB_FAST_ALL_EN (ops 0/1 use a one-cycle flash
// clear of all E bits instead of a walk; adds the flash_clr_o port).
module tlb_inv_engine
    import tlb_types::*;
#(
    parameter int TLBNUM = 32,
    parameter int IDX_W  = $clog2(TLBNUM)
) (
    input  logic             clk,
    input  logic             rst,
    input  tlb_inv_t         inv_i,
    output logic             inv_stallreq_o,
    output logic             inv_done_o,
    output logic             rd_en_o,
    output logic [IDX_W-1:0] rd_index_o,
    input  logic             rd_e_i,
    input  logic             rd_g_i,
    input  logic [9:0]       rd_asid_i,
    input  logic [18:0]      rd_vppn_i,
    input  logic [5:0]       rd_ps_i,
`ifdef INVTLB_FAST_ALL_EN
    output logic             flash_clr_o,
`endif
    output logic             clr_we_o,
    output logic [IDX_W-1:0] clr_index_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLBNUM - 1);

    inv_state_t       state_q;
    inv_state_t       state_d;
    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] cnt_d;
    logic             accept;

    logic [4:0]       op_q;
    logic [9:0]       asid_q;
    logic [18:0]      vpn_q;

    logic             vld_p1;
    logic [IDX_W-1:0] idx_p1;
    logic             match_p1;

`ifdef INVTLB_FAST_ALL_EN
    logic             flash_st;
`endif

    assign accept = (state_q == IDLE) && inv_i.en;

    // State register, walk counter and the compare-stage tag of the last read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vld_p1  <= 1'b0;
            idx_p1  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_p1  <= (state_q == WALK);
            idx_p1  <= cnt_q;
        end
    end

    // Operand capture on accept; these only feed the comparator, so no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= inv_i.op;
            asid_q <= inv_i.asid;
            vpn_q  <= inv_i.vpn;
        end
    end

    // Next-state, counter and control outputs; stall is combinational in the accept cycle
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        inv_stallreq_o = 1'b0;
        inv_done_o     = 1'b0;
        rd_en_o        = 1'b0;
`ifdef INVTLB_FAST_ALL_EN
        flash_st       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (inv_i.en) begin
                    inv_stallreq_o = 1'b1;
                    cnt_d          = '0;
                    if (inv_i.op > INV_OP_G_OR_ASID_VA) begin
                        state_d = DONE;
`ifdef INVTLB_FAST_ALL_EN
                    end else if (inv_i.op == INV_OP_ALL0 || inv_i.op == INV_OP_ALL1) begin
                        state_d = FLASH;
`endif
                    end else begin
                        state_d = WALK;
                    end
                end
            end
            WALK: begin
                inv_stallreq_o = 1'b1;
                rd_en_o        = 1'b1;
                cnt_d          = cnt_q + IDX_W'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                inv_stallreq_o = 1'b1;
                state_d        = DONE;
            end
            DONE: begin
                // Commit still presents the same INVTLB here, so en is ignored
                inv_done_o = 1'b1;
                state_d    = IDLE;
            end
`ifdef INVTLB_FAST_ALL_EN
            FLASH: begin
                inv_stallreq_o = 1'b1;
                flash_st       = 1'b1;
                state_d        = DONE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef INVTLB_FAST_ALL_EN
    assign flash_clr_o = flash_st;
`endif

    assign rd_index_o = cnt_q;

    // ---- compare stage (p1): read data returned for the entry issued last cycle ----
    tlb_inv_match u_match (
        .op       (op_q),
        .asid     (asid_q),
        .vpn      (vpn_q),
        .ent_g    (rd_g_i),
        .ent_asid (rd_asid_i),
        .ent_vppn (rd_vppn_i),
        .ent_ps   (rd_ps_i),
        .match    (match_p1)
    );

    assign clr_we_o    = vld_p1 && rd_e_i && match_p1;
    assign clr_index_o = idx_p1;

endmodule

// File: tb/tb_tlb_inv_engine.sv
// Self-checking bench for tlb_inv_engine: emulates the TLB array with a
// registered read port, keeps a cycle-level behavioural model of the engine
// and checks every DUT output on every falling clock edge.
module tb_tlb_inv_engine;
    import tlb_types::*;

    localparam int TLBNUM = 32;
    localparam int IDX_W  = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    tlb_inv_t         inv;
    logic             stall, done, rd_en, clr_we;
    logic             rd_e, rd_g;
    logic [IDX_W-1:0] rd_idx, clr_idx;
    logic [9:0]       rd_asid;
    logic [18:0]      rd_vppn;
    logic [5:0]       rd_ps;
`ifdef INVTLB_FAST_ALL_EN
    logic             flash;
    int               n_flash, flash_cyc;
`endif

    always #5 clk = ~clk;

    tlb_inv_engine #(.TLBNUM(TLBNUM), .IDX_W(IDX_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .inv_i          (inv),
        .inv_stallreq_o (stall),
        .inv_done_o     (done),
        .rd_en_o        (rd_en),
        .rd_index_o     (rd_idx),
        .rd_e_i         (rd_e),
        .rd_g_i         (rd_g),
        .rd_asid_i      (rd_asid),
        .rd_vppn_i      (rd_vppn),
        .rd_ps_i        (rd_ps),
`ifdef INVTLB_FAST_ALL_EN
        .flash_clr_o    (flash),
`endif
        .clr_we_o       (clr_we),
        .clr_index_o    (clr_idx)
    );

    // TLB array contents
    logic        tlb_e   [TLBNUM];
    logic        ld_e    [TLBNUM];
    logic        tlb_g   [TLBNUM];
    logic [9:0]  tlb_asid[TLBNUM];
    logic [18:0] tlb_vppn[TLBNUM];
    logic [5:0]  tlb_ps  [TLBNUM];
    logic        ld_req = 1'b0;

    // TLB array: registered read port, E-bit clear port, bulk load
    always @(posedge clk) begin
        if (ld_req) begin
            for (int i = 0; i < TLBNUM; i++) tlb_e[i] <= ld_e[i];
        end else begin
            if (rd_en) begin
                rd_e    <= tlb_e[rd_idx];
                rd_g    <= tlb_g[rd_idx];
                rd_asid <= tlb_asid[rd_idx];
                rd_vppn <= tlb_vppn[rd_idx];
                rd_ps   <= tlb_ps[rd_idx];
            end
            if (clr_we) tlb_e[clr_idx] <= 1'b0;
`ifdef INVTLB_FAST_ALL_EN
            if (flash) begin
                for (int i = 0; i < TLBNUM; i++) tlb_e[i] <= 1'b0;
            end
`endif
        end
    end

    int n_chk = 0, n_pass = 0, cyc = 0;
    int n_stall, n_clr, n_rd, n_done, done_cyc, acc_cyc;

    function automatic void chk(string name, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Reference selection rule for one entry
    function automatic bit spec_match(int op, bit g, logic [9:0] a_ent, logic [9:0] a_req,
                                      logic [18:0] v_ent, logic [18:0] v_req, int ps);
        bit asid_hit = (a_ent == a_req);
        bit va_hit   = (ps == 21) ? ((v_ent >> 9) == (v_req >> 9)) : (v_ent == v_req);
        case (op)
            0, 1:    return 1'b1;
            2:       return g;
            3:       return !g;
            4:       return !g && asid_hit;
            5:       return !g && asid_hit && va_hit;
            6:       return (g || asid_hit) && va_hit;
            default: return 1'b0;
        endcase
    endfunction

    // Model: an accepted op is described by its start cycle, kind and clear set
    bit m_act = 1'b0;
    int m_t0, m_len, m_kind;   // kind 0 walk, 1 invalid, 2 flash
    bit m_clr[TLBNUM];

    function automatic void model_accept();
        int op = int'(inv.op);
        m_act   = 1'b1;
        m_t0    = cyc;
        acc_cyc = cyc;
        if (op > 6) begin
            m_kind = 1; m_len = 1;
        end else begin
            m_kind = 0; m_len = TLBNUM + 2;
`ifdef INVTLB_FAST_ALL_EN
            if (op <= 1) begin m_kind = 2; m_len = 2; end
`endif
        end
        for (int i = 0; i < TLBNUM; i++)
            m_clr[i] = tlb_e[i] && spec_match(op, tlb_g[i], tlb_asid[i], inv.asid,
                                              tlb_vppn[i], inv.vpn, int'(tlb_ps[i]));
    endfunction

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin : cmp
        int d;
        bit e_stall, e_done, e_rd, e_clr, e_flash;
        if (!rst) begin
            m_act = 1'b0;
            chk("reset_stall", stall, 0);
            chk("reset_done", done, 0);
            chk("reset_rd_en", rd_en, 0);
            chk("reset_rd_index", rd_idx, 0);
            chk("reset_clr_we", clr_we, 0);
            chk("reset_clr_index", clr_idx, 0);
`ifdef INVTLB_FAST_ALL_EN
            chk("reset_flash", flash, 0);
`endif
        end else begin
            cyc++;
            if (m_act && (cyc - m_t0) > m_len) m_act = 1'b0;
            if (!m_act && inv.en) model_accept();
            e_stall = 0; e_done = 0; e_rd = 0; e_clr = 0; e_flash = 0;
            d = cyc - m_t0;
            if (m_act) begin
                case (m_kind)
                    0: begin
                        e_stall = (d <= TLBNUM + 1);
                        e_rd    = (d >= 1 && d <= TLBNUM);
                        if (d >= 2 && d <= TLBNUM + 1) e_clr = m_clr[d-2];
                        e_done  = (d == TLBNUM + 2);
                    end
                    1: begin
                        e_stall = (d == 0);
                        e_done  = (d == 1);
                    end
                    default: begin
                        e_stall = (d <= 1);
                        e_flash = (d == 1);
                        e_done  = (d == 2);
                    end
                endcase
            end
            chk("stall", stall, e_stall);
            chk("done", done, e_done);
            chk("rd_en", rd_en, e_rd);
            chk("clr_we", clr_we, e_clr);
            if (e_rd)  chk("rd_index", rd_idx, d - 1);
            if (e_clr) chk("clr_index", clr_idx, d - 2);
`ifdef INVTLB_FAST_ALL_EN
            chk("flash_clr", flash, e_flash);
            if (flash) begin n_flash++; flash_cyc = cyc; end
`endif
            if (stall)  n_stall++;
            if (clr_we) n_clr++;
            if (rd_en)  n_rd++;
            if (done) begin n_done++; done_cyc = cyc; end
        end
    end

    task automatic clear_stats();
        n_stall = 0; n_clr = 0; n_rd = 0; n_done = 0; done_cyc = -1;
`ifdef INVTLB_FAST_ALL_EN
        n_flash = 0; flash_cyc = -1;
`endif
    endtask

    // mode 0: distinct non-global entries; mode 1: G alternates, ASID 0x12 low half / 0x34 high half
    task automatic fill(input int mode);
        for (int i = 0; i < TLBNUM; i++) begin
            ld_e[i]     = 1'b1;
            tlb_g[i]    = (mode == 1) ? i[0] : 1'b0;
            tlb_asid[i] = (mode == 1) ? ((i < 16) ? 10'h12 : 10'h34) : 10'(32'h100 + i);
            tlb_vppn[i] = 19'(i);
            tlb_ps[i]   = 6'd12;
        end
    endtask

    task automatic load();
        @(posedge clk); #1;
        ld_req = 1'b1;
        @(posedge clk); #1;
        ld_req = 1'b0;
    endtask

    function automatic int count_zero();
        int n = 0;
        for (int i = 0; i < TLBNUM; i++) if (!tlb_e[i]) n++;
        return n;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (m_act && n < 200) begin @(posedge clk); n++; end
        chk("op_completes_in_budget", m_act, 0);
    endtask

    task automatic run_op(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vpn);
        clear_stats();
        @(posedge clk); #1;
        inv.en = 1'b1; inv.op = op; inv.asid = asid; inv.vpn = vpn;
        @(posedge clk); #1;
        inv.en = 1'b0;
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, first_done;
        inv = '0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("lit_reset_stall", stall, 0);
        chk("lit_reset_rd_index", rd_idx, 0);
        rst = 1'b1;

        // Op 0 over a full array
        fill(0); load();
        run_op(5'd0, 10'h0, 19'h0);
`ifdef INVTLB_FAST_ALL_EN
        chk("op0_flash_stall_cycles", n_stall, 2);
        chk("op0_flash_done_offset", done_cyc - acc_cyc, 2);
`else
        chk("op0_clr_pulses", n_clr, 32);
        chk("op0_stall_cycles", n_stall, 34);
        chk("op0_done_offset", done_cyc - acc_cyc, 34);
`endif
        chk("op0_all_cleared", count_zero(), 32);

        // Op 5: entry 9 differs only by G=1
        fill(0);
        tlb_asid[7] = 10'h12; tlb_vppn[7] = 19'h1A2B4;
        tlb_g[9] = 1'b1; tlb_asid[9] = 10'h12; tlb_vppn[9] = 19'h1A2B4;
        load();
        run_op(5'd5, 10'h12, 19'h1A2B4);
        chk("op5_e7", tlb_e[7], 0);
        chk("op5_e9", tlb_e[9], 1);
        chk("op5_cleared", count_zero(), 1);

        // Op 6 on a 4MB global page: low 9 VPPN bits are ignored
        fill(0);
        tlb_g[3] = 1'b1; tlb_ps[3] = 6'd21; tlb_vppn[3] = 19'h1A200;
        load();
        run_op(5'd6, 10'h55, 19'h1A3FF);
        chk("op6_e3", tlb_e[3], 0);
        chk("op6_cleared", count_zero(), 1);

        // Op 4 on the mixed array: G=0 and ASID 0x12 -> even indices below 16
        fill(1); load();
        run_op(5'd4, 10'h12, 19'h0);
        chk("op4_clr_pulses", n_clr, 8);
        chk("op4_e2", tlb_e[2], 0);
        chk("op4_e18", tlb_e[18], 1);

        // Op 2 with an already-invalid global entry: it must not be written
        fill(1); ld_e[1] = 1'b0; load();
        run_op(5'd2, 10'h0, 19'h0);
        chk("op2_clr_pulses", n_clr, 15);
        chk("op2_zero_entries", count_zero(), 16);

        // Invalid op
        fill(0); load();
        run_op(5'd9, 10'h0, 19'h0);
        chk("inv_stall_cycles", n_stall, 1);
        chk("inv_done_offset", done_cyc - acc_cyc, 1);
        chk("inv_no_writes", n_clr, 0);
        chk("inv_no_reads", n_rd, 0);

        // Op 1
        fill(0); load();
        run_op(5'd1, 10'h0, 19'h0);
`ifdef INVTLB_FAST_ALL_EN
        chk("op1_no_reads", n_rd, 0);
        chk("op1_flash_offset", flash_cyc - acc_cyc, 1);
        chk("op1_done_offset", done_cyc - acc_cyc, 2);
`else
        chk("op1_clr_pulses", n_clr, 32);
`endif
        chk("op1_all_cleared", count_zero(), 32);

        // Reset in the middle of an op 3 walk at T+10
        fill(0); load();
        clear_stats();
        @(posedge clk); #1;
        inv.en = 1'b1; inv.op = 5'd3; inv.asid = 10'h0; inv.vpn = 19'h0;
        @(posedge clk); #1;
        inv.en = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_stall", stall, 0);
        chk("midrst_rd_en", rd_en, 0);
        chk("midrst_clr_we", clr_we, 0);
        chk("midrst_done", done, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        chk("midrst_cleared", count_zero(), 8);
        chk("midrst_e7", tlb_e[7], 0);
        chk("midrst_e8", tlb_e[8], 1);
        chk("midrst_no_done", n_done, 0);

        // Back-to-back: op 3 held through DONE, then op 9 the next cycle
        fill(0); load();
        clear_stats();
        @(posedge clk); #1;
        inv.en = 1'b1; inv.op = 5'd3; inv.asid = 10'h0; inv.vpn = 19'h0;
        n = 0;
        while (n_done == 0 && n < 100) begin @(posedge clk); n++; end
        chk("b2b_first_done_seen", n_done, 1);
        first_done = done_cyc;
        #1;
        inv.op = 5'd9;
        @(posedge clk); #1;
        inv.en = 1'b0;
        wait_idle();
        chk("b2b_done_count", n_done, 2);
        chk("b2b_done_gap", done_cyc - first_done, 2);
        chk("b2b_first_walk_clears", n_clr, 32);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
